i2c_cmd_arbiter: RTL and testbench
==================================

# i2c_cmd_arbiter

Round-robin arbiter and sequencer sharing one I2C write engine among several requesters (power-up initializer, runtime volume/mute control, sample-rate switch). Each requester supplies a 16-bit codec register word; the block prepends the 7-bit device address plus write bit and issues one 24-bit write to the downstream byte/bit engine. It retries NACKed transfers, enforces a bus-free gap between transfers, and reports completion or failure per requester.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DEV_ADDR, 8'h34, address byte (7-bit address + R/W=0) prepended to every command
- MAX_RETRY, 3, extra attempts after a NACK (0 = no retry)
- GAP_CYC, 4, idle cycles between consecutive transfers (>=1)
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  N_REQ  request per requester; held with data until its o_grant pulse
- i_req_data  in  16*N_REQ  register word; requester k uses bits [16k+15:16k]
- o_grant  out  N_REQ  one-cycle pulse: request k accepted, data captured
- o_done  out  N_REQ  one-cycle pulse: requester k's write ACKed
- o_err  out  N_REQ  one-cycle pulse: requester k's write failed after all retries
- o_busy  out  1  high whenever state != S_IDLE
- o_cmd_valid  out  1  command to engine valid
- o_cmd_data  out  24  {DEV_ADDR, word}, stable while o_cmd_valid
- i_cmd_ready  in  1  engine accepts command when high with o_cmd_valid
- i_cmd_done  in  1  one-cycle pulse: engine finished transfer
- i_cmd_ack_ok  in  1  qualifies i_cmd_done: 1 = all three bytes ACKed, 0 = NACK

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_GAP.
- S_IDLE: if any i_req high, winner = first set bit searching upward (wrapping) from last_r+1; capture word, winner index; pulse o_grant[winner]; retry_cnt := 0; last_r := winner; go S_ISSUE.
- last_r resets to N_REQ-1, so requester 0 has first priority after reset.
- S_ISSUE: o_cmd_valid=1, o_cmd_data={DEV_ADDR, word}; on i_cmd_ready sampled high go S_WAIT.
- S_WAIT: on i_cmd_done: ack_ok=1 → result OK; ack_ok=0 and retry_cnt<MAX_RETRY → retry_cnt+1, retry pending; ack_ok=0 and retry_cnt==MAX_RETRY → result ERR. Always go S_GAP, gap counter := 0.
- S_GAP: count GAP_CYC cycles; on exit go S_ISSUE if retry pending, else S_IDLE.
- o_done[winner] / o_err[winner] pulse in the first S_GAP cycle for OK/ERR results; no pulse on retries.
- Requester must drop i_req the cycle it sees o_grant; a still-high i_req is treated as a new request at the next S_IDLE.
- i_req changes outside S_IDLE are ignored; no pre-emption.
- i_cmd_done outside S_WAIT ignored; i_cmd_ready outside S_ISSUE ignored.
- retry_cnt width = $clog2(MAX_RETRY+1); gap counter width = $clog2(GAP_CYC+1).

## Timing
- Reset: state S_IDLE, o_grant/o_done/o_err=0, o_busy=0, o_cmd_valid=0, o_cmd_data=0, last_r=N_REQ-1, retry_cnt=0.
- All outputs registered or decoded from registered state; no combinational path from i_* to o_*.
- i_req high at edge 0 → o_grant pulse and o_cmd_valid both high in cycle 1.
- i_cmd_ready high at edge n → o_cmd_valid low from cycle n+1.
- i_cmd_done at edge m → o_done/o_err in cycle m+1; o_busy low from cycle m+1+GAP_CYC (no retry).
- Retry: o_cmd_valid reasserts in cycle m+1+GAP_CYC with identical o_cmd_data.
- Reset mid-transfer: immediate abandon, no o_done/o_err; engine reset separately by same i_rst_n.
- Minimum back-to-back spacing between grants: 3+GAP_CYC cycles with zero-latency engine.

## Test plan
- Single request: i_req=4'b0001, data 16'h0097, ready immediate, done+ack_ok=1 → o_grant[0] cycle 1, o_cmd_data=24'h340097, o_done[0] one pulse, o_busy low after gap.
- Simultaneous: i_req=4'b1111 held (dropped per grant) → grant order 0,1,2,3; then re-raise 0 and 3 after serving 1 → next order 3,0 (follows last_r).
- Backpressure: i_cmd_ready low 10 cycles → o_cmd_valid and o_cmd_data stable 10 cycles, single acceptance.
- NACK then ACK: first done ack_ok=0, second ack_ok=1 → two identical commands, GAP_CYC idle between, one o_done, no o_err.
- Retry exhaustion: MAX_RETRY=3, all NACK → exactly 4 commands, single o_err pulse, no o_done, next request then served.
- Reset in S_WAIT: assert i_rst_n low mid-transfer → all outputs 0 asynchronously, later i_cmd_done ignored, requester 0 wins next arbitration.

Source files
------------

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin arbiter and sequencer in front of a single
// I2C write engine. The winning requester's 16-bit codec register word is
// prefixed with the device address byte and issued as one 24-bit write.
// NACKed writes are retried, a bus-free gap separates transfers, and
// completion or failure is pulsed back to the owning requester.
module i2c_cmd_arbiter #(
    parameter int          N_REQ     = 4,
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int          MAX_RETRY = 3,
    parameter int          GAP_CYC   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [16*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]      o_grant,
    output logic [N_REQ-1:0]      o_done,
    output logic [N_REQ-1:0]      o_err,
    output logic                  o_busy,
    output logic                  o_cmd_valid,
    output logic [23:0]           o_cmd_data,
    input  logic                  i_cmd_ready,
    input  logic                  i_cmd_done,
    input  logic                  i_cmd_ack_ok
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GC_W  = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last_r, last_nxt;       // most recent winner; also the current owner
    logic [15:0]        word_r, word_nxt;
    logic [RC_W-1:0]    retry_cnt, retry_nxt;
    logic [GC_W-1:0]    gap_cnt, gap_nxt;
    logic               retry_pend, pend_nxt;
    logic [N_REQ-1:0]   grant_r, grant_nxt;
    logic [N_REQ-1:0]   done_r, done_nxt;
    logic [N_REQ-1:0]   err_r, err_nxt;

    // Round-robin search scratch
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W:0]     cand;

    // Next-state, datapath and pulse decode for the sequencer
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_nxt = state;
        last_nxt  = last_r;
        word_nxt  = word_r;
        retry_nxt = retry_cnt;
        gap_nxt   = gap_cnt;
        pend_nxt  = retry_pend;
        grant_nxt = '0;
        done_nxt  = '0;
        err_nxt   = '0;
        found     = 1'b0;
        pick      = '0;
        cand      = '0;

        // Search upward from the slot after the last winner, wrapping once
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last_r} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (!found && i_req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end

        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt       = S_ISSUE;
                    last_nxt        = pick;
                    word_nxt        = i_req_data[{pick, 4'b0000} +: 16];
                    retry_nxt       = '0;
                    pend_nxt        = 1'b0;
                    grant_nxt[pick] = 1'b1;
                end
            end
            S_ISSUE: begin
                if (i_cmd_ready)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_cmd_done) begin
                    state_nxt = S_GAP;
                    gap_nxt   = '0;
                    pend_nxt  = 1'b0;
                    if (i_cmd_ack_ok) begin
                        done_nxt[last_r] = 1'b1;
                    end else if (retry_cnt < RC_W'(MAX_RETRY)) begin
                        retry_nxt = retry_cnt + 1'b1;
                        pend_nxt  = 1'b1;
                    end else begin
                        err_nxt[last_r] = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GC_W'(GAP_CYC - 1))
                    state_nxt = retry_pend ? S_ISSUE : S_IDLE;
                else
                    gap_nxt = gap_cnt + 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            last_r     <= IDX_W'(N_REQ - 1);
            word_r     <= '0;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            retry_pend <= 1'b0;
            grant_r    <= '0;
            done_r     <= '0;
            err_r      <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values, independent of statement order.
            state      <= state_nxt;
            last_r     <= last_nxt;
            word_r     <= word_nxt;
            retry_cnt  <= retry_nxt;
            gap_cnt    <= gap_nxt;
            retry_pend <= pend_nxt;
            grant_r    <= grant_nxt;
            done_r     <= done_nxt;
            err_r      <= err_nxt;
        end
    end

    assign o_grant     = grant_r;
    assign o_done      = done_r;
    assign o_err       = err_r;
    assign o_busy      = (state != S_IDLE);
    assign o_cmd_valid = (state == S_ISSUE);
    assign o_cmd_data  = o_cmd_valid ? {DEV_ADDR, word_r} : 24'h0;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed scenarios plus a randomized round-robin /
// retry run checked against a queue-free behavioural model of arbitration
// order and per-transfer retry outcome.
module tb_i2c_cmd_arbiter;

    localparam int         N     = 4;
    localparam logic [7:0] ADDR  = 8'h34;
    localparam int         MAXR  = 3;
    localparam int         GAP   = 4;
    localparam int         LIMIT = 200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      i_req = '0;
    logic [16*N-1:0]   i_req_data = '0;
    logic [N-1:0]      o_grant, o_done, o_err;
    logic              o_busy, o_cmd_valid;
    logic [23:0]       o_cmd_data;
    logic              i_cmd_ready = 1'b0;
    logic              i_cmd_done = 1'b0;
    logic              i_cmd_ack_ok = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    i2c_cmd_arbiter #(
        .N_REQ(N), .DEV_ADDR(ADDR), .MAX_RETRY(MAXR), .GAP_CYC(GAP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(i_req), .i_req_data(i_req_data),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err),
        .o_busy(o_busy), .o_cmd_valid(o_cmd_valid), .o_cmd_data(o_cmd_data),
        .i_cmd_ready(i_cmd_ready), .i_cmd_done(i_cmd_done), .i_cmd_ack_ok(i_cmd_ack_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = '0;
        i_cmd_ready = 1'b0;
        i_cmd_done = 1'b0;
        i_cmd_ack_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g, output bit to);
        int n = 0;
        to = 1'b0;
        do begin
            tick();
            n++;
        end while (o_grant === '0 && n < LIMIT);
        g = o_grant;
        if (o_grant === '0) to = 1'b1;
    endtask

    // Behaves like the downstream engine for one command
    task automatic serve_cmd(input int rdy_dly, input int done_dly, input bit ack,
                             output logic [23:0] data, output bit to);
        int n = 0;
        to = 1'b0;
        data = 'x;
        while (o_cmd_valid !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        if (o_cmd_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        data = o_cmd_data;
        repeat (rdy_dly) tick();
        i_cmd_ready = 1'b1;
        tick();
        i_cmd_ready = 1'b0;
        repeat (done_dly) tick();
        i_cmd_done = 1'b1;
        i_cmd_ack_ok = ack;
        tick();
        i_cmd_done = 1'b0;
        i_cmd_ack_ok = 1'b0;
    endtask

    task automatic wait_idle(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (o_busy === 1'b1 && n < LIMIT) begin
            if (o_cmd_valid === 1'b1) saw_valid = 1'b1;
            tick();
            n++;
        end
    endtask

    // Reference: first pending requester after 'last', wrapping
    function automatic int rr_pick(input int last, input logic [N-1:0] m);
        for (int i = 1; i <= N; i++)
            if (m[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (o_grant !== '0) begin n_fail++; $display("FAIL reset_grant got %b exp 0", o_grant); end
        n_checks++; if (o_done !== '0) begin n_fail++; $display("FAIL reset_done got %b exp 0", o_done); end
        n_checks++; if (o_err !== '0) begin n_fail++; $display("FAIL reset_err got %b exp 0", o_err); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        n_checks++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_cmd_valid); end
        n_checks++; if (o_cmd_data !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", o_cmd_data); end
    endtask

    task automatic test_single();
        int n; bit sv;
        i_req = 4'b0001;
        i_req_data[15:0] = 16'h0097;
        tick();
        n_checks++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b exp 0001", o_grant); end
        n_checks++; if (o_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", o_cmd_valid); end
        n_checks++; if (o_cmd_data !== 24'h340097) begin n_fail++; $display("FAIL single_data got %h exp 340097", o_cmd_data); end
        i_req = '0;
        i_cmd_ready = 1'b1;
        tick();
        i_cmd_ready = 1'b0;
        n_checks++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got %b exp 0", o_cmd_valid); end
        i_cmd_done = 1'b1;
        i_cmd_ack_ok = 1'b1;
        tick();
        i_cmd_done = 1'b0;
        i_cmd_ack_ok = 1'b0;
        n_checks++; if (o_done !== 4'b0001) begin n_fail++; $display("FAIL single_done got %b exp 0001", o_done); end
        n_checks++; if (o_err !== 4'b0000) begin n_fail++; $display("FAIL single_err got %b exp 0000", o_err); end
        tick();
        n_checks++; if (o_done !== 4'b0000) begin n_fail++; $display("FAIL single_done_pulse got %b exp 0000", o_done); end
        wait_idle(n, sv);
        n_checks++; if (n + 1 !== GAP) begin n_fail++; $display("FAIL single_gap got %0d exp %0d", n + 1, GAP); end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] g; bit to; logic [23:0] d;
        int t_prev;
        logic [N-1:0] pend;
        int order_a [4] = '{0, 1, 2, 3};
        int order_b [3] = '{1, 3, 0};
        do_reset();
        for (int k = 0; k < N; k++) i_req_data[16*k +: 16] = 16'h1100 + 16'(k);
        pend = 4'b1111;
        i_req = pend;
        t_prev = 0;
        for (int s = 0; s < 4; s++) begin
            wait_grant(g, to);
            n_checks++; if (to || g !== (4'b0001 << order_a[s])) begin n_fail++; $display("FAIL simul_order[%0d] got %b exp %b", s, g, 4'b0001 << order_a[s]); end
            if (s > 0) begin
                n_checks++; if (cycle - t_prev !== 3 + GAP) begin n_fail++; $display("FAIL simul_spacing got %0d exp %0d", cycle - t_prev, 3 + GAP); end
            end
            t_prev = cycle;
            pend = pend & ~g;
            i_req = pend;
            serve_cmd(0, 0, 1'b1, d, to);
            n_checks++; if (to || d !== {ADDR, 16'h1100 + 16'(order_a[s])}) begin n_fail++; $display("FAIL simul_data got %h", d); end
        end
        // serve 1 alone, then raise 0 and 3 together: order follows last winner
        for (int s = 0; s < 3; s++) begin
            if (s == 0) i_req = 4'b0010;
            if (s == 1) i_req = 4'b1001;
            wait_grant(g, to);
            n_checks++; if (to || g !== (4'b0001 << order_b[s])) begin n_fail++; $display("FAIL simul_rr[%0d] got %b exp %b", s, g, 4'b0001 << order_b[s]); end
            i_req = i_req & ~g;
            serve_cmd(0, 0, 1'b1, d, to);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g; bit to; int n; bit sv;
        logic [15:0] w;
        w = 16'($urandom);
        i_req_data[32 +: 16] = w;
        i_req = 4'b0100;
        wait_grant(g, to);
        i_req = '0;
        n_checks++; if (to || g !== 4'b0100) begin n_fail++; $display("FAIL bp_grant got %b exp 0100", g); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (o_cmd_valid !== 1'b1 || o_cmd_data !== {ADDR, w}) begin n_fail++; $display("FAIL bp_stable[%0d] got v=%b d=%h exp v=1 d=%h", i, o_cmd_valid, o_cmd_data, {ADDR, w}); end
        end
        i_cmd_ready = 1'b1;
        tick();
        n_checks++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept got %b exp 0", o_cmd_valid); end
        repeat (3) begin
            tick();
            n_checks++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single got %b exp 0", o_cmd_valid); end
        end
        i_cmd_ready = 1'b0;
        i_cmd_done = 1'b1;
        i_cmd_ack_ok = 1'b1;
        tick();
        i_cmd_done = 1'b0;
        i_cmd_ack_ok = 1'b0;
        n_checks++; if (o_done !== 4'b0100) begin n_fail++; $display("FAIL bp_done got %b exp 0100", o_done); end
        wait_idle(n, sv);
    endtask

    task automatic test_nack_ack();
        logic [N-1:0] g; bit to; logic [23:0] d1, d2; int n; bit sv;
        i_req_data[48 +: 16] = 16'hA55A;
        i_req = 4'b1000;
        wait_grant(g, to);
        i_req = '0;
        serve_cmd(1, 0, 1'b0, d1, to);
        n_checks++; if (o_done !== '0 || o_err !== '0) begin n_fail++; $display("FAIL na_retry_pulse got done=%b err=%b exp 0 0", o_done, o_err); end
        n = 0;
        while (o_cmd_valid !== 1'b1 && n < LIMIT) begin tick(); n++; end
        n_checks++; if (n !== GAP) begin n_fail++; $display("FAIL na_gap got %0d exp %0d", n, GAP); end
        serve_cmd(0, 2, 1'b1, d2, to);
        n_checks++; if (d1 !== 24'h34A55A || d2 !== d1) begin n_fail++; $display("FAIL na_data got %h/%h exp 34a55a", d1, d2); end
        n_checks++; if (o_done !== 4'b1000 || o_err !== '0) begin n_fail++; $display("FAIL na_result got done=%b err=%b exp 1000 0", o_done, o_err); end
        wait_idle(n, sv);
        n_checks++; if (sv) begin n_fail++; $display("FAIL na_extra_cmd got 1 exp 0"); end
    endtask

    task automatic test_retry_exhaust();
        logic [N-1:0] g; bit to; logic [23:0] d; int n; bit sv;
        i_req_data[16 +: 16] = 16'h0C3C;
        i_req = 4'b0010;
        wait_grant(g, to);
        i_req = '0;
        for (int a = 0; a <= MAXR; a++) begin
            serve_cmd(0, 1, 1'b0, d, to);
            n_checks++; if (to || d !== 24'h340C3C) begin n_fail++; $display("FAIL ex_cmd[%0d] got %h exp 340c3c", a, d); end
            if (a < MAXR) begin
                n_checks++; if (o_err !== '0 || o_done !== '0) begin n_fail++; $display("FAIL ex_early got err=%b done=%b exp 0 0", o_err, o_done); end
            end
        end
        n_checks++; if (o_err !== 4'b0010 || o_done !== '0) begin n_fail++; $display("FAIL ex_result got err=%b done=%b exp 0010 0", o_err, o_done); end
        wait_idle(n, sv);
        n_checks++; if (sv) begin n_fail++; $display("FAIL ex_fifth_cmd got 1 exp 0"); end
        i_req = 4'b0001;
        wait_grant(g, to);
        i_req = '0;
        n_checks++; if (to || g !== 4'b0001) begin n_fail++; $display("FAIL ex_next got %b exp 0001", g); end
        serve_cmd(0, 0, 1'b1, d, to);
        wait_idle(n, sv);
    endtask

    task automatic test_reset_in_wait();
        logic [N-1:0] g; bit to; logic [23:0] d; int n; bit sv;
        i_req = 4'b0100;
        wait_grant(g, to);
        i_req = '0;
        serve_cmd(0, 0, 1'b1, d, to);
        wait_idle(n, sv);
        i_req = 4'b0100;
        wait_grant(g, to);
        i_req = '0;
        i_cmd_ready = 1'b1;
        tick();
        i_cmd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({o_grant, o_done, o_err, o_busy, o_cmd_valid, o_cmd_data} !== '0) begin n_fail++; $display("FAIL rst_async got g=%b d=%b e=%b b=%b v=%b data=%h exp all 0", o_grant, o_done, o_err, o_busy, o_cmd_valid, o_cmd_data); end
        tick();
        rst_n = 1'b1;
        i_cmd_done = 1'b1;
        i_cmd_ack_ok = 1'b1;
        tick();
        i_cmd_done = 1'b0;
        i_cmd_ack_ok = 1'b0;
        n_checks++; if (o_done !== '0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_stale_done got done=%b busy=%b exp 0 0", o_done, o_busy); end
        i_req = 4'b1111;
        wait_grant(g, to);
        i_req = '0;
        n_checks++; if (to || g !== 4'b0001) begin n_fail++; $display("FAIL rst_priority got %b exp 0001", g); end
        serve_cmd(0, 0, 1'b1, d, to);
        wait_idle(n, sv);
    endtask

    task automatic test_random();
        logic [N-1:0] pend, raise, g;
        logic [15:0]  words [N];
        bit to, sv;
        int model_last, exp_w, nacks, attempts, n;
        logic [23:0] d;
        do_reset();
        model_last = N - 1;
        pend = '0;
        for (int t = 0; t < 40; t++) begin
            raise = N'($urandom) & ~pend;
            if ((pend | raise) == '0) raise = N'(1 << $urandom_range(0, N - 1));
            for (int k = 0; k < N; k++)
                if (raise[k]) begin
                    words[k] = 16'($urandom);
                    i_req_data[16*k +: 16] = words[k];
                end
            pend = pend | raise;
            i_req = pend;
            exp_w = rr_pick(model_last, pend);
            wait_grant(g, to);
            n_checks++; if (to || g !== N'(1 << exp_w)) begin n_fail++; $display("FAIL rand_grant[%0d] got %b exp %b", t, g, N'(1 << exp_w)); end
            model_last = exp_w;
            pend[exp_w] = 1'b0;
            i_req = pend;
            nacks = $urandom_range(0, MAXR + 1);
            attempts = (nacks > MAXR) ? MAXR + 1 : nacks + 1;
            for (int a = 0; a < attempts; a++) begin
                serve_cmd($urandom_range(0, 3), $urandom_range(0, 3), (a == nacks), d, to);
                n_checks++; if (to || d !== {ADDR, words[exp_w]}) begin n_fail++; $display("FAIL rand_data[%0d.%0d] got %h exp %h", t, a, d, {ADDR, words[exp_w]}); end
                if (a < attempts - 1) begin
                    n_checks++; if (o_done !== '0 || o_err !== '0) begin n_fail++; $display("FAIL rand_retry[%0d] got done=%b err=%b exp 0 0", t, o_done, o_err); end
                end
            end
            if (nacks > MAXR) begin
                n_checks++; if (o_err !== N'(1 << exp_w) || o_done !== '0) begin n_fail++; $display("FAIL rand_err[%0d] got err=%b done=%b", t, o_err, o_done); end
            end else begin
                n_checks++; if (o_done !== N'(1 << exp_w) || o_err !== '0) begin n_fail++; $display("FAIL rand_done[%0d] got done=%b err=%b", t, o_done, o_err); end
            end
            wait_idle(n, sv);
            n_checks++; if (sv || n >= LIMIT) begin n_fail++; $display("FAIL rand_idle[%0d] got extra=%b cycles=%0d", t, sv, n); end
        end
        i_req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_nack_ack();
        test_retry_exhaust();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
